// File: rtl/irda_nec_transmitter.sv
// Purpose: memory-mapped NEC IR transmitter; serialises a written {addr,cmd} word into a 38 kHz-modulated NEC frame.
// Latency: the frame starts the cycle after an accepted DATA write; oIRDA_TXD is registered, one cycle behind the state.
// Backpressure: DATA writes while busy are dropped and flagged in ovf. Define IRDA_TX_REPEAT_EN for NEC repeat codes.
module irda_nec_transmitter #(
  parameter logic [31:0] BASE_ADDR      = 32'hFF20_0600,
  parameter int          CLK_HZ         = 50_000_000,
  parameter int          UNIT_CYCLES    = CLK_HZ * 9 / 16000,
  parameter int          CARRIER_CYCLES = CLK_HZ / 38000
) (
  input  logic        iCLK,
  input  logic        Reset_N,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  inout  wire  [31:0] wReadData,
  output logic        oIRDA_TXD
);

  localparam int UW = $clog2(UNIT_CYCLES + 1);
  localparam int PW = $clog2(CARRIER_CYCLES + 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] CAR_LAST  = PW'(CARRIER_CYCLES - 1);
  localparam logic [PW-1:0] CAR_HIGH  = PW'(CARRIER_CYCLES / 3);
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + 32'd4;

`ifdef IRDA_TX_REPEAT_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK,
    S_GAP, S_REP_MARK, S_REP_SPACE, S_REP_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [UW-1:0]   unit_cnt_q, unit_cnt_d;
  logic [4:0]      dur_cnt_q, dur_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic [15:0]     data_q, data_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            txd_q, txd_d;
  logic            rep_bit;
`ifdef IRDA_TX_REPEAT_EN
  logic            rep_q, rep_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
`endif

  logic        wr_data_hit, wr_ctrl_hit, rd_ctrl_hit, rd_data_hit;
  logic        unit_tick, state_end;
  logic [31:0] status;
  logic        unused_bits;

  // Carrier-modulated states: the LED toggles at the carrier rate here, and is dark everywhere else.
  function automatic logic is_mark(input state_t s);
    case (s)
      S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: is_mark = 1'b1;
`ifdef IRDA_TX_REPEAT_EN
      S_REP_MARK, S_REP_STOP:               is_mark = 1'b1;
`endif
      default:                              is_mark = 1'b0;
    endcase
  endfunction

  // Length of each timed state in units, minus one; a '1' bit stretches its space to 3T.
  function automatic logic [4:0] dur_last(input state_t s, input logic bit0);
    case (s)
      S_LEAD_MARK:  dur_last = 5'd15;
      S_LEAD_SPACE: dur_last = 5'd7;
      S_BIT_SPACE:  dur_last = bit0 ? 5'd2 : 5'd0;
`ifdef IRDA_TX_REPEAT_EN
      S_REP_MARK:   dur_last = 5'd15;
      S_REP_SPACE:  dur_last = 5'd3;
`endif
      default:      dur_last = 5'd0;
    endcase
  endfunction

  assign wr_data_hit = wWriteEnable && (wAddress == DATA_ADDR) && (wByteEnable[1:0] == 2'b11);
  assign wr_ctrl_hit = wWriteEnable && (wAddress == BASE_ADDR);
  assign rd_ctrl_hit = wReadEnable && (wAddress == BASE_ADDR);
  assign rd_data_hit = wReadEnable && (wAddress == DATA_ADDR);

  assign unit_tick = (unit_cnt_q == UNIT_LAST);
  assign state_end = unit_tick && (dur_cnt_q == dur_last(state_q, shift_q[0]));

`ifdef IRDA_TX_REPEAT_EN
  assign rep_bit = rep_q;
`else
  assign rep_bit = 1'b0;
`endif

  assign status    = {28'd0, rep_bit, ovf_q, done_q, busy_q};
  assign wReadData = rd_ctrl_hit ? status :
                     rd_data_hit ? {16'd0, data_q} : 32'hzzzz_zzzz;
  assign oIRDA_TXD = txd_q;

  // Upper data bits and byte lanes carry nothing for this block.
  assign unused_bits = ^{wByteEnable[3:2], wWriteData[31:16]};

  // Next-state logic: unit timing, frame sequencing, register writes, carrier phase.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    unit_cnt_d = (state_q == S_IDLE || unit_tick) ? '0 : unit_cnt_q + 1'b1;
    dur_cnt_d  = state_end ? '0 : (unit_tick ? dur_cnt_q + 1'b1 : dur_cnt_q);
`ifdef IRDA_TX_REPEAT_EN
    rep_d       = rep_q;
    frame_cnt_d = unit_tick ? frame_cnt_q + 1'b1 : frame_cnt_q;
`endif

    case (state_q)
      S_LEAD_MARK:  if (state_end) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (state_end) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (state_end) state_d = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (state_end) begin
          shift_d   = {1'b0, shift_q[31:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK: begin
        if (state_end) begin
`ifdef IRDA_TX_REPEAT_EN
          if (rep_q) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef IRDA_TX_REPEAT_EN
      // Hold dark until 192T after the previous frame/repeat began; leave at once if rep is dropped.
      S_GAP: begin
        dur_cnt_d = '0;
        if (!rep_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (unit_tick && frame_cnt_q == 8'd191) begin
          state_d     = S_REP_MARK;
          frame_cnt_d = '0;
        end
      end
      S_REP_MARK:  if (state_end) state_d = S_REP_SPACE;
      S_REP_SPACE: if (state_end) state_d = S_REP_STOP;
      S_REP_STOP: begin
        if (state_end) begin
          if (rep_q) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase

    // busy_q is sampled before this edge's end-of-frame update, so a write on the final stop cycle is rejected.
    if (wr_data_hit) begin
      if (busy_q) begin
        ovf_d = 1'b1;
      end else begin
        data_d     = wWriteData[15:0];
        shift_d    = {~wWriteData[7:0], wWriteData[7:0], ~wWriteData[15:8], wWriteData[15:8]};
        bit_cnt_d  = '0;
        unit_cnt_d = '0;
        dur_cnt_d  = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        state_d    = S_LEAD_MARK;
`ifdef IRDA_TX_REPEAT_EN
        frame_cnt_d = '0;
`endif
      end
    end

    if (wr_ctrl_hit) begin
      if (wWriteData[2]) ovf_d = 1'b0;
`ifdef IRDA_TX_REPEAT_EN
      rep_d = wWriteData[0];
`endif
    end

    // Phase restarts on every mark entry so each mark opens with a full high third.
    if (!is_mark(state_d) || state_d != state_q || phase_q == CAR_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
    txd_d = is_mark(state_q) && (phase_q < CAR_HIGH);
  end

  // State registers with synchronous active-low reset; a reset abandons any frame in flight.
  always_ff @(posedge iCLK) begin
    if (!Reset_N) begin
      state_q    <= S_IDLE;
      unit_cnt_q <= '0;
      dur_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      phase_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      txd_q      <= 1'b0;
`ifdef IRDA_TX_REPEAT_EN
      rep_q       <= 1'b0;
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      txd_q      <= txd_d;
`ifdef IRDA_TX_REPEAT_EN
      rep_q       <= rep_d;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_irda_nec_transmitter.sv
// Bench for irda_nec_transmitter: random NEC frames compared cycle by cycle against a segment-level frame model.
// The NEC unit is shortened to 60 cycles (carrier 42 cycles, 14 high) to keep each 121T frame short.
// Scenario tasks run in sequence from one initial block and end with a single summary line.
module tb_irda_nec_transmitter;
  localparam logic [31:0] BASE  = 32'hFF20_0600;
  localparam int          U     = 60;
  localparam int          CAR   = 42;
  localparam int          HI    = CAR / 3;
  localparam int          FRAME = 121 * U;
  localparam logic [31:0] PAT   = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        tb_drv = 1'b0;
  wire  [31:0] rdata;
  wire         txd;
  int          n_checks = 0;
  int          n_fail = 0;

  // The bench drives a known pattern on the shared bus to see whether the DUT releases it.
  assign rdata = tb_drv ? PAT : 32'hzzzz_zzzz;

  irda_nec_transmitter #(
    .BASE_ADDR(BASE), .CLK_HZ(1_600_000), .UNIT_CYCLES(U), .CARRIER_CYCLES(CAR)
  ) dut (
    .iCLK(clk), .Reset_N(rst_n), .wReadEnable(re), .wWriteEnable(we), .wByteEnable(be),
    .wAddress(addr), .wWriteData(wdata), .wReadData(rdata), .oIRDA_TXD(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; addr = a; wdata = d; be = b; re = 1'b0;
    tick();
    we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    #1;
    d = rdata;
    re = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_probe(input logic [31:0] a, input logic rd, output logic [31:0] d);
    re = rd; addr = a; tb_drv = 1'b1;
    #1;
    d = rdata;
    re = 1'b0; addr = 32'd0; tb_drv = 1'b0;
  endtask

  function automatic bit carrier_at(input int k);
    return (k % CAR) < HI;
  endfunction

  // LED level during frame cycle j: leader 16T mark + 8T space, 32 bits (1T mark, 1T/3T space), 1T stop mark.
  // Bits leave LSB first in byte order addr, ~addr, cmd, ~cmd.
  function automatic bit model_txd(input int j, input logic [15:0] d);
    logic [7:0] octet [4];
    int pos;
    octet[0] = d[15:8]; octet[1] = ~d[15:8]; octet[2] = d[7:0]; octet[3] = ~d[7:0];
    if (j < 0) return 1'b0;
    if (j < 16 * U) return carrier_at(j);
    pos = 24 * U;
    if (j < pos) return 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (j < pos + U) return carrier_at(j - pos);
      pos += U;
      pos += (octet[i / 8][i % 8] ? 3 : 1) * U;
      if (j < pos) return 1'b0;
    end
    if (j < pos + U) return carrier_at(j - pos);
    return 1'b0;
  endfunction

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (txd !== 1'b0) begin n_fail++; $display("FAIL reset_txd: got %b expected 0", txd); end
    rst_n = 1'b1;
    tick();
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 00000000", r); end
    bus_probe(BASE, 1'b0, r);
    n_checks++;
    if (r !== PAT) begin n_fail++; $display("FAIL bus_release_noread: got %h expected %h", r, PAT); end
    bus_probe(BASE + 32'd8, 1'b1, r);
    n_checks++;
    if (r !== PAT) begin n_fail++; $display("FAIL bus_release_unmapped: got %h expected %h", r, PAT); end
    bus_write(BASE + 32'd4, 32'h0000_00FF, 4'b0001);
    repeat (2) tick();
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL partial_lane_write: got %h expected 00000000", r); end
  endtask

  task automatic test_frame(input logic [15:0] d);
    logic [31:0] r;
    int busy_cyc, fall_at, wave_err, first_bad, lead_hi, space_hi, exp_lead_hi;
    busy_cyc = 0; fall_at = -1; wave_err = 0; first_bad = -1; lead_hi = 0; space_hi = 0;
    exp_lead_hi = (16 * U / CAR) * HI + (((16 * U) % CAR) < HI ? (16 * U) % CAR : HI);
    bus_write(BASE + 32'd4, {16'd0, d}, 4'b0011);
    for (int n = 0; n <= FRAME + 2; n++) begin
      if (n > 0) tick();
      bus_read(BASE, r);
      if (r[0] === 1'b1) busy_cyc++;
      else if (fall_at < 0) fall_at = n;
      if (txd !== model_txd(n - 1, d)) begin
        wave_err++;
        if (first_bad < 0) first_bad = n;
      end
      if (n >= 1 && n <= 16 * U && txd === 1'b1) lead_hi++;
      if (n > 16 * U && n <= 24 * U && txd === 1'b1) space_hi++;
    end
    n_checks++;
    if (wave_err != 0) begin n_fail++; $display("FAIL frame_wave %h: %0d bad cycles, first at %0d, expected 0", d, wave_err, first_bad); end
    n_checks++;
    if (lead_hi != exp_lead_hi) begin n_fail++; $display("FAIL lead_mark_high %h: got %0d expected %0d", d, lead_hi, exp_lead_hi); end
    n_checks++;
    if (space_hi != 0) begin n_fail++; $display("FAIL lead_space_high %h: got %0d expected 0", d, space_hi); end
    n_checks++;
    if (busy_cyc != FRAME) begin n_fail++; $display("FAIL busy_length %h: got %0d expected %0d", d, busy_cyc, FRAME); end
    n_checks++;
    if (fall_at != FRAME) begin n_fail++; $display("FAIL busy_fall %h: got %0d expected %0d", d, fall_at, FRAME); end
    n_checks++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL done_status %h: got %h expected 00000002", d, r); end
    bus_read(BASE + 32'd4, r);
    n_checks++;
    if (r !== {16'd0, d}) begin n_fail++; $display("FAIL data_readback: got %h expected %h", r, {16'd0, d}); end
    bus_probe(BASE + 32'd4, 1'b0, r);
    n_checks++;
    if (r !== PAT) begin n_fail++; $display("FAIL bus_release_idle: got %h expected %h", r, PAT); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [15:0] d;
    int k, n, fall;
    d = 16'($urandom);
    k = $urandom_range(FRAME - 200, 10);
    bus_write(BASE + 32'd4, {16'd0, d}, 4'b0011);
    repeat (k) tick();
    bus_write(BASE + 32'd4, 32'h0000_1234, 4'b1111);
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h5) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000005", r); end
    bus_read(BASE + 32'd4, r);
    n_checks++;
    if (r !== {16'd0, d}) begin n_fail++; $display("FAIL ovf_data_kept: got %h expected %h", r, {16'd0, d}); end
    bus_write(BASE, 32'h4, 4'b1111);
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000001", r); end
    n = k + 2; fall = -1;
    while (n < FRAME + 10) begin
      tick(); n++;
      bus_read(BASE, r);
      if (r[0] !== 1'b1) begin fall = n; break; end
    end
    n_checks++;
    if (fall != FRAME) begin n_fail++; $display("FAIL ovf_frame_len: got %0d expected %0d", fall, FRAME); end
    n_checks++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL ovf_end_status: got %h expected 00000002", r); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    int j;
    j = 25 * U + $urandom_range(U - 1, 0);
    bus_write(BASE + 32'd4, {16'd0, 16'($urandom)}, 4'b0011);
    repeat (j) tick();
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h1) begin n_fail++; $display("FAIL midframe_busy: got %h expected 00000001", r); end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (txd !== 1'b0) begin n_fail++; $display("FAIL midreset_txd: got %b expected 0", txd); end
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_status: got %h expected 00000000", r); end
    rst_n = 1'b1;
    repeat (2 * U) tick();
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h0 || txd !== 1'b0) begin n_fail++; $display("FAIL no_resume: status %h txd %b expected 00000000 and 0", r, txd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [15:0] d1, d2;
    int n, fall;
    d1 = 16'($urandom); d2 = 16'($urandom);
    bus_write(BASE + 32'd4, {16'd0, d1}, 4'b0011);
    repeat (FRAME - 1) tick();
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h1) begin n_fail++; $display("FAIL last_cycle_busy: got %h expected 00000001", r); end
    bus_write(BASE + 32'd4, {16'd0, d2}, 4'b0011);
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h6) begin n_fail++; $display("FAIL collide_status: got %h expected 00000006", r); end
    bus_read(BASE + 32'd4, r);
    n_checks++;
    if (r !== {16'd0, d1}) begin n_fail++; $display("FAIL collide_data: got %h expected %h", r, {16'd0, d1}); end
    bus_write(BASE + 32'd4, {16'd0, d2}, 4'b0011);
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h5) begin n_fail++; $display("FAIL restart_status: got %h expected 00000005", r); end
    bus_write(BASE, 32'h4, 4'b1111);
    n = 1; fall = -1;
    while (n < FRAME + 10) begin
      tick(); n++;
      bus_read(BASE, r);
      if (r[0] !== 1'b1) begin fall = n; break; end
    end
    n_checks++;
    if (fall != FRAME) begin n_fail++; $display("FAIL restart_frame_len: got %0d expected %0d", fall, FRAME); end
    bus_read(BASE + 32'd4, r);
    n_checks++;
    if (r !== {16'd0, d2}) begin n_fail++; $display("FAIL restart_data: got %h expected %h", r, {16'd0, d2}); end
  endtask

`ifdef IRDA_TX_REPEAT_EN
  // Frame, then repeat codes every 192T: 16T mark, 4T space, 1T mark; two repeats are sent here.
  function automatic bit model_rep(input int j, input logic [15:0] d);
    int k;
    if (j < 192 * U) return model_txd(j, d);
    if (j >= 405 * U) return 1'b0;
    k = (j - 192 * U) % (192 * U);
    if (k < 16 * U) return carrier_at(k);
    if (k < 20 * U) return 1'b0;
    if (k < 21 * U) return carrier_at(k - 20 * U);
    return 1'b0;
  endfunction

  task automatic test_repeat();
    logic [31:0] r;
    int wave_err, first_bad, fall_at;
    wave_err = 0; first_bad = -1; fall_at = -1;
    bus_write(BASE, 32'h1, 4'b1111);
    bus_read(BASE, r);
    n_checks++;
    if (r !== 32'h8) begin n_fail++; $display("FAIL rep_status: got %h expected 00000008", r); end
    bus_write(BASE + 32'd4, 32'h0000_0102, 4'b0011);
    for (int n = 1; n <= 405 * U + 2; n++) begin
      if (n == 389 * U) bus_write(BASE, 32'h0, 4'b1111);
      else tick();
      bus_read(BASE, r);
      if (r[0] !== 1'b1 && fall_at < 0) fall_at = n;
      if (txd !== model_rep(n - 1, 16'h0102)) begin
        wave_err++;
        if (first_bad < 0) first_bad = n;
      end
    end
    n_checks++;
    if (wave_err != 0) begin n_fail++; $display("FAIL rep_wave: %0d bad cycles, first at %0d, expected 0", wave_err, first_bad); end
    n_checks++;
    if (fall_at != 405 * U) begin n_fail++; $display("FAIL rep_busy_fall: got %0d expected %0d", fall_at, 405 * U); end
    n_checks++;
    if (r !== 32'h2) begin n_fail++; $display("FAIL rep_end_status: got %h expected 00000002", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame(16'h00FF);
    test_frame(16'($urandom));
    test_overflow();
    test_reset_midframe();
    test_frame(16'($urandom));
    test_back_to_back();
`ifdef IRDA_TX_REPEAT_EN
    test_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
